// File: rtl/mcu_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, functs,
// ALU codes, FSM states and datapath mux selects.
package mcu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADDR  = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_RWB      = 4'd7,
        S_BRANCH   = 4'd8,
        S_EXEC_I   = 4'd9,
        S_IWB      = 4'd10,
        S_JUMP     = 4'd11
    } state_e;

    typedef enum logic [2:0] {
        ALU_CLS_NONE,
        ALU_CLS_ADD,
        ALU_CLS_SUB,
        ALU_CLS_FUNCT,
        ALU_CLS_IMM
    } alu_class_e;

    function automatic logic funct_legal(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
               (funct == FN_OR)  || (funct == FN_SLT);
    endfunction

endpackage

// File: rtl/alu_control_decoder.sv
// Maps the FSM's ALU usage class plus opcode/funct onto the 4-bit ALU code.
module alu_control_decoder
    import mcu_pkg::*;
(
    input  alu_class_e  alu_class,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    output logic [3:0]  alu_control
);

    always_comb begin
        alu_control = ALU_AND;
        case (alu_class)
            ALU_CLS_ADD: alu_control = ALU_ADD;
            ALU_CLS_SUB: alu_control = ALU_SUB;
            ALU_CLS_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: alu_control = ALU_AND;
                endcase
            end
            ALU_CLS_IMM: begin
                case (opcode)
                    OP_ADDI: alu_control = ALU_ADD;
                    OP_ANDI: alu_control = ALU_AND;
                    OP_ORI:  alu_control = ALU_OR;
                    OP_SLTI: alu_control = ALU_SLT;
                    default: alu_control = ALU_AND;
                endcase
            end
            default: alu_control = ALU_AND;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared datapath and stalls on the memory-ready handshake.
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter bit          ZEXT_LOGICAL = 1'b1
)(
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           instruction,
    input  logic                  mem_ready,
    output logic [DATA_WIDTH-1:0] sign_extend,
    output logic [4:0]            read_sel_a,
    output logic [4:0]            read_sel_b,
    output logic [4:0]            write_sel,
    output logic [3:0]            ALU_Control,
    output logic                  IorD,
    output logic                  IRWrite,
    output logic                  PCWrite,
    output logic                  PCWriteCond,
    output logic                  BranchNe,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic                  MemtoReg,
    output logic                  RegWrite,
    output logic                  RegDst,
    output logic                  ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [1:0]            PCSource,
    output logic [3:0]            state,
    output logic                  instr_done,
    output logic                  illegal_op
);

    state_e     state_q, state_d;
    alu_class_e alu_class;
    logic [5:0] opcode, funct;
    logic       ext_bit;

    assign opcode     = instruction[31:26];
    assign funct      = instruction[5:0];
    assign read_sel_a = instruction[25:21];
    assign read_sel_b = instruction[20:16];
    assign write_sel  = (opcode == OP_RTYPE) ? instruction[15:11] : instruction[20:16];
    assign state      = state_q;

    // Fill first, then overlay imm so DATA_WIDTH == 16 needs no zero-width replication.
    always_comb begin
        ext_bit = instruction[15] &
                  ~(ZEXT_LOGICAL && ((opcode == OP_ANDI) || (opcode == OP_ORI)));
        sign_extend       = {DATA_WIDTH{ext_bit}};
        sign_extend[15:0] = instruction[15:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    alu_control_decoder u_alu_dec (
        .alu_class   (alu_class),
        .opcode      (opcode),
        .funct       (funct),
        .alu_control (ALU_Control)
    );

    always_comb begin
        state_d     = S_FETCH;
        alu_class   = ALU_CLS_NONE;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNe    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REGB;
        PCSource    = PCSRC_ALU;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                alu_class = ALU_CLS_ADD;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                state_d   = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB   = SRCB_IMM_SL2;
                alu_class = ALU_CLS_ADD;
                case (opcode)
                    OP_LW, OP_SW:    state_d = S_MEMADDR;
                    OP_BEQ, OP_BNE:  state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_EXEC_I;
                    OP_J:            state_d = S_JUMP;
                    OP_RTYPE: begin
                        if (funct_legal(funct)) state_d = S_EXEC_R;
                        else                    illegal_op = 1'b1;
                    end
                    default:         illegal_op = 1'b1;
                endcase
            end
            S_MEMADDR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_IMM;
                alu_class = ALU_CLS_ADD;
                state_d   = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
                state_d    = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXEC_R: begin
                ALUSrcA   = 1'b1;
                alu_class = ALU_CLS_FUNCT;
                state_d   = S_RWB;
            end
            S_RWB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                alu_class   = ALU_CLS_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                BranchNe    = (opcode == OP_BNE);
                instr_done  = 1'b1;
            end
            S_EXEC_I: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_IMM;
                alu_class = ALU_CLS_IMM;
                state_d   = S_IWB;
            end
            S_IWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = PCSRC_JUMP;
                instr_done = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-instruction step lists with random
// memory stalls predict every cycle's controls; directed cases pin the model.
module tb_multicycle_control_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        mem_ready;
    logic [31:0] sign_extend;
    logic [4:0]  read_sel_a, read_sel_b, write_sel;
    logic [3:0]  ALU_Control, state;
    logic        IorD, IRWrite, PCWrite, PCWriteCond, BranchNe, MemRead, MemWrite;
    logic        MemtoReg, RegWrite, RegDst, ALUSrcA, instr_done, illegal_op;
    logic [1:0]  ALUSrcB, PCSource;

    multicycle_control_unit #(.DATA_WIDTH(32), .ZEXT_LOGICAL(1'b1)) dut (
        .clock(clock), .reset(reset), .instruction(instruction), .mem_ready(mem_ready),
        .sign_extend(sign_extend), .read_sel_a(read_sel_a), .read_sel_b(read_sel_b),
        .write_sel(write_sel), .ALU_Control(ALU_Control), .IorD(IorD), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .state(state), .instr_done(instr_done), .illegal_op(illegal_op)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] alu;
        logic [1:0] srcb;
        logic [1:0] pcsrc;
        logic iord, irw, pcw, pcwc, bne, mrd, mwr, m2r, rw, rdst, srca, done, ill;
    } ctl_t;

    ctl_t        act, exp_ctl;
    ctl_t        snap [16];
    logic [31:0] exp_ext;
    logic [14:0] exp_sels;
    logic        chk_en = 1'b0;
    logic        wr_seen = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;

    assign act = {state, ALU_Control, ALUSrcB, PCSource, IorD, IRWrite, PCWrite,
                  PCWriteCond, BranchNe, MemRead, MemWrite, MemtoReg, RegWrite,
                  RegDst, ALUSrcA, instr_done, illegal_op};

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Single compare process: every cycle the model is armed.
    always @(negedge clock) begin
        if (chk_en) begin
            check($sformatf("ctl@step%0d", exp_ctl.st), act, exp_ctl);
            check("sign_extend", sign_extend, exp_ext);
            check("reg_sels", {read_sel_a, read_sel_b, write_sel}, exp_sels);
        end
        snap[state] = act;
        if (RegWrite || MemWrite || PCWrite) wr_seen = 1'b1;
    end

    function automatic bit is_legal(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'd0:  return fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2a;
            6'd2, 6'd4, 6'd5, 6'd8, 6'd10, 6'd12, 6'd13, 6'd35, 6'd43: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [5:0] op, input logic [5:0] fn);
        logic [5:0] key;
        key = (op == 6'd0) ? fn : op;
        case (key)
            6'h20, 6'd8:  return 4'b0010;
            6'h22:        return 4'b0110;
            6'h24, 6'd12: return 4'b0000;
            6'h25, 6'd13: return 4'b0001;
            6'h2a, 6'd10: return 4'b0111;
            default:      return 4'bxxxx;
        endcase
    endfunction

    // Expected controls for one step of an instruction, straight from the step table.
    function automatic ctl_t model(input int s, input logic [5:0] op, input logic [5:0] fn,
                                   input logic mr, input bit legal);
        ctl_t c;
        c = '0;
        c.st = 4'(s);
        case (s)
            0:  begin c.alu = 4'b0010; c.srcb = 2'b01; c.mrd = 1; c.irw = mr; c.pcw = mr; end
            1:  begin c.alu = 4'b0010; c.srcb = 2'b11; c.ill = !legal; end
            2:  begin c.alu = 4'b0010; c.srcb = 2'b10; c.srca = 1; end
            3:  begin c.mrd = 1; c.iord = 1; end
            4:  begin c.rw = 1; c.m2r = 1; c.done = 1; end
            5:  begin c.mwr = 1; c.iord = 1; c.done = mr; end
            6:  begin c.srca = 1; c.alu = alu_of(op, fn); end
            7:  begin c.rw = 1; c.rdst = 1; c.done = 1; end
            8:  begin c.srca = 1; c.alu = 4'b0110; c.pcwc = 1; c.pcsrc = 2'b01;
                      c.bne = (op == 6'd5); c.done = 1; end
            9:  begin c.srca = 1; c.srcb = 2'b10; c.alu = alu_of(op, fn); end
            10: begin c.rw = 1; c.done = 1; end
            11: begin c.pcw = 1; c.pcsrc = 2'b10; c.done = 1; end
            default: ;
        endcase
        return c;
    endfunction

    // Runs one instruction from FETCH; entered and left at posedge+1 with the DUT in FETCH.
    task automatic run_instr(input logic [31:0] instr, input bit rnd, input int stall_step,
                             input int stall_n, output int cycles);
        logic [5:0] op, fn;
        bit         legal, zx;
        int         steps[$];
        int         idx, stalls;
        logic       mr;
        op = instr[31:26];
        fn = instr[5:0];
        legal = is_legal(op, fn);
        idx = 0; stalls = 0; cycles = 0;
        if (!legal)                      steps = '{0, 1};
        else if (op == 6'd35)            steps = '{0, 1, 2, 3, 4};
        else if (op == 6'd43)            steps = '{0, 1, 2, 5};
        else if (op == 6'd0)             steps = '{0, 1, 6, 7};
        else if (op == 6'd4 || op == 6'd5) steps = '{0, 1, 8};
        else if (op == 6'd2)             steps = '{0, 1, 11};
        else                             steps = '{0, 1, 9, 10};
        zx = (op == 6'd12) || (op == 6'd13);
        while (idx < steps.size()) begin
            if (steps[idx] == stall_step && stalls < stall_n) begin
                mr = 1'b0;
                stalls++;
            end else if (rnd && cycles < 60) mr = ($urandom_range(0, 99) < 70);
            else mr = 1'b1;
            instruction = instr;
            mem_ready   = mr;
            exp_ctl  = model(steps[idx], op, fn, mr, legal);
            exp_ext  = {{16{instr[15] & !zx}}, instr[15:0]};
            exp_sels = {instr[25:21], instr[20:16], (op == 6'd0) ? instr[15:11] : instr[20:16]};
            chk_en   = 1'b1;
            @(posedge clock);
            #1;
            cycles++;
            if (!((steps[idx] == 0 || steps[idx] == 3 || steps[idx] == 5) && !mr)) idx++;
        end
        chk_en = 1'b0;
    endtask

    task automatic clear_snap();
        for (int i = 0; i < 16; i++) snap[i] = '0;
    endtask

    initial begin
        ctl_t        r;
        int          cyc, n;
        logic [5:0]  ops [11];
        logic [5:0]  fns [6];
        logic [5:0]  op;
        logic [31:0] ins;
        ops = '{6'd0, 6'd2, 6'd4, 6'd5, 6'd8, 6'd10, 6'd12, 6'd13, 6'd35, 6'd43, 6'd63};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00};

        // Reset state, with and without mem_ready.
        reset = 1'b1; mem_ready = 1'b0; instruction = 32'h0;
        #2;
        r = '0; r.alu = 4'b0010; r.srcb = 2'b01; r.mrd = 1;
        check("reset_ctl_mr0", act, r);
        mem_ready = 1'b1;
        @(posedge clock); #1;
        r.irw = 1; r.pcw = 1;
        check("reset_ctl_mr1", act, r);
        @(negedge clock);
        mem_ready = 1'b0;
        reset = 1'b0;
        @(posedge clock); #1;

        // add $3,$1,$2
        clear_snap();
        run_instr(32'h00221820, 1'b0, -1, 0, cyc);
        check("add_cycles", cyc, 4);
        check("add_alu_s6", snap[6].alu, 4'b0010);
        check("add_rw_rdst_s7", {snap[7].rw, snap[7].rdst, snap[7].done}, 3'b111);
        check("add_write_sel", write_sel, 5'd3);

        // lw $2,4($1) with two wait cycles on the data read
        clear_snap();
        run_instr(32'h8C220004, 1'b0, 3, 2, cyc);
        check("lw_cycles", cyc, 7);
        check("lw_srcb_s2", snap[2].srcb, 2'b10);
        check("lw_m2r_s4", {snap[4].m2r, snap[4].rw}, 2'b11);
        check("lw_write_sel", write_sel, 5'd2);

        // bne $1,$2,-1
        clear_snap();
        run_instr(32'h1422FFFF, 1'b0, -1, 0, cyc);
        check("bne_cycles", cyc, 3);
        check("bne_s8", {snap[8].alu, snap[8].pcwc, snap[8].bne, snap[8].pcsrc}, 8'b0110_1_1_01);
        check("bne_sext", sign_extend, 32'hFFFFFFFF);

        // ori $2,$1,0x8001 (zero-extended)
        clear_snap();
        run_instr(32'h34228001, 1'b0, -1, 0, cyc);
        check("ori_cycles", cyc, 4);
        check("ori_sext", sign_extend, 32'h00008001);
        check("ori_alu_s9", snap[9].alu, 4'b0001);
        check("ori_rw_s10", snap[10].rw, 1'b1);

        // illegal opcode 111111
        clear_snap();
        run_instr(32'hFC000000, 1'b0, -1, 0, cyc);
        check("ill_cycles", cyc, 2);
        check("ill_pulse_s1", snap[1].ill, 1'b1);

        // j and sw under fixed stalls
        run_instr(32'h08000010, 1'b0, 0, 1, cyc);
        check("j_cycles_fetch_stall", cyc, 4);
        run_instr(32'hAC220008, 1'b0, 5, 3, cyc);
        check("sw_cycles_write_stall", cyc, 7);

        // Reset in the middle of a load
        instruction = 32'h8C220004;
        mem_ready = 1'b1;
        n = 0;
        while (state != 4'd3 && n < 10) begin
            @(posedge clock); #1;
            n++;
        end
        check("reach_memread", state, 4'd3);
        mem_ready = 1'b0;
        @(negedge clock);
        wr_seen = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("midlw_rst_state", state, 4'd0);
        check("midlw_rst_memread", MemRead, 1'b1);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("midlw_no_writes", wr_seen, 1'b0);
        check("midlw_idle_fetch", state, 4'd0);

        // Random instruction stream with random memory stalls
        for (int k = 0; k < 300; k++) begin
            op  = ops[$urandom_range(0, 10)];
            if ($urandom_range(0, 15) == 0) op = 6'($urandom);
            ins = {op, 26'($urandom)};
            if (op == 6'd0) ins[5:0] = fns[$urandom_range(0, 5)];
            run_instr(ins, 1'b1, -1, 0, cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
